// File: rtl/maze_walker.sv
// maze_walker: wall-following explorer over a ROWS x COLS grid held in an
// external single-port memory. The walker starts at a given cell, follows the
// right-hand or left-hand wall, and writes a visit mark to every cell it
// enters. It stops with done on a border cell. It stops with timeout when it
// hits the step limit or when it is boxed in.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    launch pulse (ignored while busy)
//   hand_sel                 0 = right-hand rule, 1 = left-hand rule
//   starting_row/col         start cell, latched at start
//   maze_in                  memory read data (1 = wall), valid the cycle after maze_oe
//   row, col                 memory address for the current probe/mark
//   maze_oe, maze_we         read enable / visit-mark write enable
//   done, timeout, busy      run status
//   steps                    moves made in the current run
module maze_walker #(
  parameter int ADDR_W    = 6,
  parameter int ROWS      = 64,
  parameter int COLS      = 64,
  parameter int STEP_W    = 16,
  parameter int MAX_STEPS = (1 << STEP_W) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hand_sel,
  input  logic [ADDR_W-1:0] starting_row,
  input  logic [ADDR_W-1:0] starting_col,
  input  logic              maze_in,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              maze_oe,
  output logic              maze_we,
  output logic              done,
  output logic              timeout,
  output logic              busy,
  output logic [STEP_W-1:0] steps
);

  typedef enum logic [2:0] {
    S_IDLE, S_MARK, S_RD_SIDE, S_CHK_SIDE, S_RD_FWD, S_CHK_FWD, S_DONE, S_ABORT
  } state_t;

  // Headings are numbered clockwise, so +1 is a right turn and -1 a left turn.
  localparam logic [1:0] H_UP = 2'd0, H_RIGHT = 2'd1, H_DOWN = 2'd2, H_LEFT = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);
  localparam logic [STEP_W-1:0] STEP_LIM = STEP_W'(MAX_STEPS);

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_prow, r_pcol, w_prow, w_pcol;   // walker position
  logic [1:0]        r_head, w_head;
  logic              r_hand, w_hand;
  logic [STEP_W-1:0] r_steps, w_steps;
  logic [2:0]        r_turns, w_turns;
  logic [ADDR_W-1:0] r_row, r_col, w_row, w_col;        // registered memory address

  // Neighbour of (r,c) in direction h.
  function automatic logic [2*ADDR_W-1:0] f_nbr(input logic [ADDR_W-1:0] r,
                                                input logic [ADDR_W-1:0] c,
                                                input logic [1:0]        h);
    logic [ADDR_W-1:0] nr, nc;
    nr = r;
    nc = c;
    case (h)
      H_UP:    nr = r - ADDR_W'(1);
      H_RIGHT: nc = c + ADDR_W'(1);
      H_DOWN:  nr = r + ADDR_W'(1);
      default: nc = c - ADDR_W'(1);
    endcase
    return {nr, nc};
  endfunction

  // Direction of the followed wall: right of heading for the right-hand rule.
  function automatic logic [1:0] f_side(input logic [1:0] h, input logic hand);
    return hand ? h - 2'd1 : h + 2'd1;
  endfunction

  logic [1:0]          w_side_dir, w_away_dir;
  logic [2*ADDR_W-1:0] w_side_rc, w_fwd_rc;
  logic [STEP_W-1:0]   w_steps_inc;
  logic                w_at_limit, w_border;

  assign w_side_dir  = f_side(r_head, r_hand);
  assign w_away_dir  = r_hand ? r_head + 2'd1 : r_head - 2'd1;
  assign w_side_rc   = f_nbr(r_prow, r_pcol, w_side_dir);
  assign w_fwd_rc    = f_nbr(r_prow, r_pcol, r_head);
  assign w_steps_inc = r_steps + STEP_W'(1);
  assign w_at_limit  = (w_steps_inc == STEP_LIM);
  assign w_border    = (r_prow == '0) || (r_prow == LAST_ROW) ||
                       (r_pcol == '0) || (r_pcol == LAST_COL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_prow  <= '0;
      r_pcol  <= '0;
      r_head  <= H_UP;
      r_hand  <= 1'b0;
      r_steps <= '0;
      r_turns <= '0;
      r_row   <= '0;
      r_col   <= '0;
      maze_oe <= 1'b0;
      maze_we <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_prow  <= w_prow;
      r_pcol  <= w_pcol;
      r_head  <= w_head;
      r_hand  <= w_hand;
      r_steps <= w_steps;
      r_turns <= w_turns;
      r_row   <= w_row;
      r_col   <= w_col;
      // Strobes and flags are decoded from the next state so they line up
      // with the state they belong to while still leaving a flop.
      maze_oe <= (w_state == S_RD_SIDE) || (w_state == S_RD_FWD);
      maze_we <= (w_state == S_MARK);
      done    <= (w_state == S_DONE);
      timeout <= (w_state == S_ABORT);
      busy    <= !((w_state == S_IDLE) || (w_state == S_DONE) || (w_state == S_ABORT));
    end
  end

  always_comb begin
    w_state = r_state;
    w_prow  = r_prow;
    w_pcol  = r_pcol;
    w_head  = r_head;
    w_hand  = r_hand;
    w_steps = r_steps;
    w_turns = r_turns;
    case (r_state)
      S_IDLE, S_DONE, S_ABORT: begin
        if (start) begin
          w_prow  = starting_row;
          w_pcol  = starting_col;
          w_head  = H_UP;
          w_hand  = hand_sel;
          w_steps = '0;
          w_turns = '0;
          w_state = S_MARK;
        end
      end
      S_MARK:    w_state = w_border ? S_DONE : S_RD_SIDE;
      S_RD_SIDE: w_state = S_CHK_SIDE;
      S_CHK_SIDE: begin
        if (!maze_in) begin
          {w_prow, w_pcol} = w_side_rc;
          w_head  = w_side_dir;
          w_steps = w_steps_inc;
          w_turns = '0;
          w_state = w_at_limit ? S_ABORT : S_MARK;
        end else begin
          w_state = S_RD_FWD;
        end
      end
      S_RD_FWD: w_state = S_CHK_FWD;
      S_CHK_FWD: begin
        if (!maze_in) begin
          {w_prow, w_pcol} = w_fwd_rc;
          w_steps = w_steps_inc;
          w_turns = '0;
          w_state = w_at_limit ? S_ABORT : S_MARK;
        end else begin
          // Side and front blocked: turn away from the wall. A fourth turn in a
          // row means every neighbour has been probed as a wall.
          w_head  = w_away_dir;
          w_turns = r_turns + 3'd1;
          w_state = (r_turns == 3'd3) ? S_ABORT : S_RD_SIDE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // Address for the next cycle, computed from the next position/heading so it
  // is valid in the same cycle as the strobe.
  logic [2*ADDR_W-1:0] w_nside_rc, w_nfwd_rc;
  assign w_nside_rc = f_nbr(w_prow, w_pcol, f_side(w_head, w_hand));
  assign w_nfwd_rc  = f_nbr(w_prow, w_pcol, w_head);

  always_comb begin
    w_row = r_row;
    w_col = r_col;
    case (w_state)
      S_MARK:    {w_row, w_col} = {w_prow, w_pcol};
      S_RD_SIDE: {w_row, w_col} = w_nside_rc;
      S_RD_FWD:  {w_row, w_col} = w_nfwd_rc;
      default: ;
    endcase
  end

  assign row   = r_row;
  assign col   = r_col;
  assign steps = r_steps;

endmodule

// File: tb/tb_maze_walker.sv
// Directed bench for maze_walker on an 8x8 grid with a step limit of 10.
// The bench holds a behavioural single-port maze memory and logs every probe
// and every visit-mark write as {row,col}.
module tb_maze_walker;

  localparam int AW = 4;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          hand_sel = 1'b0;
  logic [AW-1:0] starting_row = '0;
  logic [AW-1:0] starting_col = '0;
  logic          maze_in = 1'b0;
  logic [AW-1:0] row, col;
  logic          maze_oe, maze_we, done, timeout, busy;
  logic [SW-1:0] steps;

  maze_walker #(.ADDR_W(AW), .ROWS(8), .COLS(8), .STEP_W(SW), .MAX_STEPS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .hand_sel(hand_sel),
    .starting_row(starting_row), .starting_col(starting_col), .maze_in(maze_in),
    .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we),
    .done(done), .timeout(timeout), .busy(busy), .steps(steps)
  );

  always #5 clk = ~clk;

  logic       wall [8][8];
  logic [7:0] mark_q[$];
  logic [7:0] probe_q[$];
  int         both_hi = 0;

  always @(posedge clk) begin
    if (maze_oe) begin
      maze_in <= wall[row[2:0]][col[2:0]];
      probe_q.push_back({row, col});
    end
    if (maze_we) mark_q.push_back({row, col});
    if (maze_oe && maze_we) both_hi++;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int m0, p0, cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_walls();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) wall[r][c] = 1'b1;
  endtask

  task automatic chk_mark(input string tag, input int i, input int r, input int c);
    chk(tag, (m0 + i < mark_q.size()) ? 32'(mark_q[m0 + i]) : 32'hFF, 32'(r * 16 + c));
  endtask

  // Called at a negedge. Pulses start, then scrambles the start inputs to
  // show they were latched. cyc = 1 is the first MARK cycle.
  task automatic launch(input logic hs, input int r, input int c);
    m0 = mark_q.size();
    p0 = probe_q.size();
    hand_sel = hs; starting_row = AW'(r); starting_col = AW'(c); start = 1'b1;
    @(negedge clk);
    start = 1'b0; hand_sel = ~hs; starting_row = '1; starting_col = '1;
    cyc = 1;
  endtask

  task automatic run(input logic hs, input int r, input int c);
    launch(hs, r, c);
    chk("start_we", maze_we, 1);
    chk("start_flags", {done, timeout, busy}, 3'b001);
    chk("start_steps", steps, 0);
    while (!(done || timeout) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("run_ends", done | timeout, 1);
    chk("busy_low_at_end", busy, 0);
  endtask

  initial begin
    fill_walls();
    #3;
    chk("rst_addr", {row, col}, 0);
    chk("rst_strobes", {maze_oe, maze_we}, 0);
    chk("rst_flags", {done, timeout, busy}, 0);
    chk("rst_steps", steps, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_flags", {done, timeout, busy}, 0);

    // Straight corridor up col 3, right-hand rule.
    fill_walls();
    for (int r = 0; r <= 5; r++) wall[r][3] = 1'b0;
    run(1'b0, 5, 3);
    chk("t1_done", {done, timeout}, 2'b10);
    chk("t1_steps", steps, 5);
    chk("t1_cycles", cyc, 27);
    chk("t1_nmarks", mark_q.size() - m0, 6);
    for (int i = 0; i < 6; i++) chk_mark("t1_mark", i, 5 - i, 3);

    // Side turn into a corridor running right.
    fill_walls();
    wall[4][4] = 1'b0; wall[4][5] = 1'b0; wall[4][6] = 1'b0; wall[4][7] = 1'b0;
    run(1'b0, 4, 4);
    chk("t2_done", {done, timeout}, 2'b10);
    chk("t2_steps", steps, 3);
    chk("t2_col", col, 7);
    chk_mark("t2_mark1", 1, 4, 5);
    chk_mark("t2_mark3", 3, 4, 7);
    // After turning RIGHT the right-hand side cell is below.
    chk("t2_probe_after_turn", (p0 + 1 < probe_q.size()) ? 32'(probe_q[p0 + 1]) : 32'hFF, 32'h55);
    chk("t2_cycles", cyc, 15);

    // Mirror image with the left-hand rule.
    fill_walls();
    wall[4][3] = 1'b0; wall[4][2] = 1'b0; wall[4][1] = 1'b0; wall[4][0] = 1'b0;
    run(1'b1, 4, 3);
    chk("t3_done", {done, timeout}, 2'b10);
    chk("t3_steps", steps, 3);
    chk("t3_nmarks", mark_q.size() - m0, 4);
    for (int i = 0; i < 4; i++) chk_mark("t3_mark", i, 4, 3 - i);

    // Boxed-in start cell.
    fill_walls();
    wall[3][3] = 1'b0;
    run(1'b0, 3, 3);
    chk("t4_flags", {done, timeout}, 2'b01);
    chk("t4_steps", steps, 0);
    chk("t4_nmarks", mark_q.size() - m0, 1);
    chk("t4_nprobes", probe_q.size() - p0, 8);
    chk("t4_cycles", cyc, 18);

    // Closed ring around (3,3): runs until the step limit.
    fill_walls();
    for (int r = 2; r <= 4; r++)
      for (int c = 2; c <= 4; c++) wall[r][c] = 1'b0;
    wall[3][3] = 1'b1;
    run(1'b0, 2, 2);
    chk("t5_flags", {done, timeout}, 2'b01);
    chk("t5_steps", steps, 10);
    chk("t5_nmarks", mark_q.size() - m0, 10);
    chk_mark("t5_mark1", 1, 2, 3);
    // Restart from ABORT with the other hand; run checks the restart cycle.
    run(1'b1, 2, 2);
    chk("t5b_flags", {done, timeout}, 2'b01);
    chk("t5b_steps", steps, 10);
    chk_mark("t5b_mark1", 1, 2, 3);

    // Reset in the middle of a forward check.
    fill_walls();
    for (int r = 0; r <= 5; r++) wall[r][3] = 1'b0;
    launch(1'b0, 5, 3);
    while (probe_q.size() - p0 < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_pre_steps", steps, 1);
    chk("t6_pre_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_addr", {row, col}, 0);
    chk("t6_rst_strobes", {maze_oe, maze_we}, 0);
    chk("t6_rst_flags", {done, timeout, busy}, 0);
    chk("t6_rst_steps", steps, 0);
    m0 = mark_q.size();
    repeat (3) @(negedge clk);
    chk("t6_no_write_in_rst", mark_q.size() - m0, 0);
    rst = 1'b0;
    @(negedge clk);
    run(1'b0, 5, 3);
    chk("t6_after_done", {done, timeout}, 2'b10);
    chk("t6_after_steps", steps, 5);

    // Start cell on the border.
    run(1'b0, 0, 2);
    chk("t7_done", {done, timeout}, 2'b10);
    chk("t7_steps", steps, 0);
    chk("t7_nmarks", mark_q.size() - m0, 1);
    chk("t7_nprobes", probe_q.size() - p0, 0);
    chk("t7_cycles", cyc, 2);

    // Start while busy is ignored.
    fill_walls();
    for (int r = 0; r <= 5; r++) wall[r][3] = 1'b0;
    launch(1'b0, 5, 3);
    repeat (3) @(negedge clk);
    start = 1'b1; starting_row = 4'd2; starting_col = 4'd2;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(done || timeout) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("t8_done", {done, timeout}, 2'b10);
    chk("t8_steps", steps, 5);

    chk("oe_we_exclusive", both_hi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
